// File: rtl/hand_pkg.sv
// hand_pkg: shared widths, screen geometry and FSM state type for the hand tracker.
//   Screen geometry drives the coordinate and count widths. pix_x carries one spare bit.
package hand_pkg;
    localparam int unsigned SCREEN_W  = 1024;
    localparam int unsigned SCREEN_H  = 768;
    localparam int unsigned COORD_X_W = $clog2(SCREEN_W) + 1;       // 11
    localparam int unsigned COORD_Y_W = $clog2(SCREEN_H);           // 10
    localparam int unsigned CNT_W     = $clog2(SCREEN_W * SCREEN_H); // 20
    // Holds 786432 * 1023 without overflow.
    localparam int unsigned SUM_W     = 30;

    typedef enum logic [2:0] {
        StIdle,
        StDivX1,
        StDivY1,
        StDivX2,
        StDivY2,
        StCommit
    } state_e;
endpackage

// File: rtl/hand_tracker_seq_divider.sv
// seq_divider: unsigned restoring divider, SUM_W-bit dividend by CNT_W-bit divisor.
//   clk, reset : clock, synchronous active-high reset
//   start      : load operands (ignored while busy)
//   dividend   : numerator
//   divisor    : denominator
//   busy       : iterating
//   done       : one-cycle pulse, quotient valid
//   quotient   : low QUOT_W bits of floor(dividend/divisor), 0 when divisor is 0
// Fixed latency: 1 load cycle, 31 iteration cycles, 1 done cycle.
module seq_divider
    import hand_pkg::*;
#(
    parameter int unsigned QUOT_W = SUM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SUM_W-1:0]  dividend,
    input  logic [CNT_W-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [QUOT_W-1:0] quotient
);
    localparam int unsigned ITERS = SUM_W + 1;

    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [SUM_W:0]   dvd_q, dvd_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dsr_q, dsr_d;
    logic [4:0]       iter_q, iter_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W:0]   rem_shift;
    logic [CNT_W-1:0] rem_sub;

    always_comb begin
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        iter_d    = iter_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rem_shift = {rem_q, dvd_q[SUM_W]};
        // Only used when rem_shift >= divisor, so the low bits are exact.
        rem_sub   = rem_shift[CNT_W-1:0] - dsr_q;
        if (busy_q) begin
            if (rem_shift >= {1'b0, dsr_q}) begin
                rem_d = rem_sub;
                dvd_d = {dvd_q[SUM_W-1:0], 1'b1};
            end else begin
                rem_d = rem_shift[CNT_W-1:0];
                dvd_d = {dvd_q[SUM_W-1:0], 1'b0};
            end
            if (iter_q == 5'(ITERS - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                iter_d = iter_q + 5'd1;
            end
        end else if (start) begin
            dvd_d  = {1'b0, dividend};
            rem_d  = '0;
            dsr_d  = divisor;
            iter_d = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = (dsr_q == '0) ? '0 : dvd_q[QUOT_W-1:0];
endmodule

// File: rtl/hand_tracker.sv
// hand_tracker: turns the classified pixel stream into per-frame hand centroids,
// tracking flags and debounced grab flags for two hands.
//   clk, reset               : pixel clock, synchronous active-high reset
//   pix_valid, pix_x, pix_y  : pixel qualifier and coordinates
//   pix_hand1/2, pix_grab1/2 : glove / grab marker class hits
//   frame_end                : pulse after the last pixel (a coincident pixel still counts)
//   hand1x/y, hand2x/y       : committed centroids
//   grab1/2, track1/2        : committed flags
//   update                   : one-cycle pulse when outputs are committed
//   frame_drop               : one-cycle pulse when a frame arrives while still computing
module hand_tracker
    import hand_pkg::*;
#(
    parameter int unsigned MIN_PIXELS  = 64,
    parameter int unsigned GRAB_THRESH = 32,
    parameter int unsigned GRAB_FRAMES = 2,
    parameter int unsigned RESET_X1    = 256,
    parameter int unsigned RESET_X2    = 768,
    parameter int unsigned RESET_Y     = 384
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_valid,
    input  logic [COORD_X_W-1:0] pix_x,
    input  logic [COORD_Y_W-1:0] pix_y,
    input  logic                 pix_hand1,
    input  logic                 pix_hand2,
    input  logic                 pix_grab1,
    input  logic                 pix_grab2,
    input  logic                 frame_end,
    output logic [COORD_X_W-1:0] hand1x,
    output logic [COORD_X_W-1:0] hand2x,
    output logic [COORD_Y_W-1:0] hand1y,
    output logic [COORD_Y_W-1:0] hand2y,
    output logic                 grab1,
    output logic                 grab2,
    output logic                 track1,
    output logic                 track2,
    output logic                 update,
    output logic                 frame_drop
);
    localparam int unsigned DEB_W = $clog2(GRAB_FRAMES + 1);

    state_e state_q, state_d;
    logic [1:0] hit_hand, hit_grab;

    // Live accumulators, frame snapshot and their pixel-updated totals.
    logic [CNT_W-1:0] cnt_q [2], cnt_d [2], acc_cnt [2], snap_cnt_q [2], snap_cnt_d [2];
    logic [CNT_W-1:0] gcnt_q [2], gcnt_d [2], acc_gcnt [2], snap_gcnt_q [2], snap_gcnt_d [2];
    logic [SUM_W-1:0] sumx_q [2], sumx_d [2], acc_sx [2], snap_sx_q [2], snap_sx_d [2];
    logic [SUM_W-1:0] sumy_q [2], sumy_d [2], acc_sy [2], snap_sy_q [2], snap_sy_d [2];

    logic [COORD_X_W-1:0] qx_q [2], qx_d [2], hx_q [2], hx_d [2];
    logic [COORD_Y_W-1:0] qy_q [2], qy_d [2], hy_q [2], hy_d [2];
    logic [DEB_W-1:0]     deb_q [2], deb_d [2];
    logic [1:0]           grab_q, grab_d, track_q, track_d;
    logic                 update_q, update_d, drop_q, drop_d;
    logic                 tracked, cand;

    logic                 div_start, div_busy, div_done;
    logic [SUM_W-1:0]     div_dividend;
    logic [CNT_W-1:0]     div_divisor;
    logic [COORD_X_W-1:0] div_quot;

    assign hit_hand = {pix_hand2, pix_hand1};
    assign hit_grab = {pix_grab2, pix_grab1};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            acc_cnt[i]  = cnt_q[i];
            acc_gcnt[i] = gcnt_q[i];
            acc_sx[i]   = sumx_q[i];
            acc_sy[i]   = sumy_q[i];
            if (pix_valid && hit_hand[i]) begin
                acc_cnt[i] = cnt_q[i] + CNT_W'(1);
                acc_sx[i]  = sumx_q[i] + SUM_W'(pix_x);
                acc_sy[i]  = sumy_q[i] + SUM_W'(pix_y);
            end
            if (pix_valid && hit_grab[i]) begin
                acc_gcnt[i] = gcnt_q[i] + CNT_W'(1);
            end
            cnt_d[i]       = frame_end ? '0 : acc_cnt[i];
            gcnt_d[i]      = frame_end ? '0 : acc_gcnt[i];
            sumx_d[i]      = frame_end ? '0 : acc_sx[i];
            sumy_d[i]      = frame_end ? '0 : acc_sy[i];
            snap_cnt_d[i]  = snap_cnt_q[i];
            snap_gcnt_d[i] = snap_gcnt_q[i];
            snap_sx_d[i]   = snap_sx_q[i];
            snap_sy_d[i]   = snap_sy_q[i];
            // A busy pipeline keeps the old snapshot; the new frame is dropped.
            if (frame_end && (state_q == StIdle)) begin
                snap_cnt_d[i]  = acc_cnt[i];
                snap_gcnt_d[i] = acc_gcnt[i];
                snap_sx_d[i]   = acc_sx[i];
                snap_sy_d[i]   = acc_sy[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        update_d     = 1'b0;
        drop_d       = frame_end && (state_q != StIdle);
        div_start    = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        grab_d       = grab_q;
        track_d      = track_q;
        tracked      = 1'b0;
        cand         = 1'b0;
        for (int i = 0; i < 2; i++) begin
            qx_d[i]  = qx_q[i];
            qy_d[i]  = qy_q[i];
            hx_d[i]  = hx_q[i];
            hy_d[i]  = hy_q[i];
            deb_d[i] = deb_q[i];
        end
        unique case (state_q)
            StIdle: begin
                if (frame_end) state_d = StDivX1;
            end
            StDivX1, StDivY1, StDivX2, StDivY2: begin
                div_start = !div_busy && !div_done;
                unique case (state_q)
                    StDivX1: begin
                        div_dividend = snap_sx_q[0];
                        div_divisor  = snap_cnt_q[0];
                    end
                    StDivY1: begin
                        div_dividend = snap_sy_q[0];
                        div_divisor  = snap_cnt_q[0];
                    end
                    StDivX2: begin
                        div_dividend = snap_sx_q[1];
                        div_divisor  = snap_cnt_q[1];
                    end
                    default: begin
                        div_dividend = snap_sy_q[1];
                        div_divisor  = snap_cnt_q[1];
                    end
                endcase
                if (div_done) begin
                    unique case (state_q)
                        StDivX1: begin qx_d[0] = div_quot; state_d = StDivY1; end
                        StDivY1: begin qy_d[0] = div_quot[COORD_Y_W-1:0]; state_d = StDivX2; end
                        StDivX2: begin qx_d[1] = div_quot; state_d = StDivY2; end
                        default: begin qy_d[1] = div_quot[COORD_Y_W-1:0]; state_d = StCommit; end
                    endcase
                end
            end
            StCommit: begin
                update_d = 1'b1;
                state_d  = StIdle;
                for (int i = 0; i < 2; i++) begin
                    tracked    = snap_cnt_q[i] >= CNT_W'(MIN_PIXELS);
                    cand       = tracked && (snap_gcnt_q[i] >= CNT_W'(GRAB_THRESH));
                    track_d[i] = tracked;
                    if (!tracked) begin
                        // Lost hand releases immediately.
                        grab_d[i] = 1'b0;
                        deb_d[i]  = '0;
                    end else begin
                        hx_d[i] = qx_q[i];
                        hy_d[i] = qy_q[i];
                        if (cand == grab_q[i]) begin
                            deb_d[i] = '0;
                        end else if (32'(deb_q[i]) + 32'd1 >= GRAB_FRAMES) begin
                            grab_d[i] = ~grab_q[i];
                            deb_d[i]  = '0;
                        end else begin
                            deb_d[i] = deb_q[i] + DEB_W'(1);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    seq_divider #(
        .QUOT_W(COORD_X_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (div_divisor),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_quot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            update_q <= 1'b0;
            drop_q   <= 1'b0;
            grab_q   <= '0;
            track_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]       <= '0;
                gcnt_q[i]      <= '0;
                sumx_q[i]      <= '0;
                sumy_q[i]      <= '0;
                snap_cnt_q[i]  <= '0;
                snap_gcnt_q[i] <= '0;
                snap_sx_q[i]   <= '0;
                snap_sy_q[i]   <= '0;
                qx_q[i]        <= '0;
                qy_q[i]        <= '0;
                deb_q[i]       <= '0;
                hy_q[i]        <= COORD_Y_W'(RESET_Y);
            end
            hx_q[0] <= COORD_X_W'(RESET_X1);
            hx_q[1] <= COORD_X_W'(RESET_X2);
        end else begin
            state_q  <= state_d;
            update_q <= update_d;
            drop_q   <= drop_d;
            grab_q   <= grab_d;
            track_q  <= track_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]       <= cnt_d[i];
                gcnt_q[i]      <= gcnt_d[i];
                sumx_q[i]      <= sumx_d[i];
                sumy_q[i]      <= sumy_d[i];
                snap_cnt_q[i]  <= snap_cnt_d[i];
                snap_gcnt_q[i] <= snap_gcnt_d[i];
                snap_sx_q[i]   <= snap_sx_d[i];
                snap_sy_q[i]   <= snap_sy_d[i];
                qx_q[i]        <= qx_d[i];
                qy_q[i]        <= qy_d[i];
                deb_q[i]       <= deb_d[i];
                hx_q[i]        <= hx_d[i];
                hy_q[i]        <= hy_d[i];
            end
        end
    end

    assign hand1x     = hx_q[0];
    assign hand2x     = hx_q[1];
    assign hand1y     = hy_q[0];
    assign hand2y     = hy_q[1];
    assign grab1      = grab_q[0];
    assign grab2      = grab_q[1];
    assign track1     = track_q[0];
    assign track2     = track_q[1];
    assign update     = update_q;
    assign frame_drop = drop_q;
endmodule

// File: tb/tb_hand_tracker.sv
module tb_hand_tracker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic [10:0] pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        pix_hand1 = 1'b0, pix_hand2 = 1'b0, pix_grab1 = 1'b0, pix_grab2 = 1'b0;
    logic        frame_end = 1'b0;
    logic [10:0] hand1x, hand2x;
    logic [9:0]  hand1y, hand2y;
    logic        grab1, grab2, track1, track2, update, frame_drop;

    always #5 clk = ~clk;

    hand_tracker dut (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_hand1 (pix_hand1),
        .pix_hand2 (pix_hand2),
        .pix_grab1 (pix_grab1),
        .pix_grab2 (pix_grab2),
        .frame_end (frame_end),
        .hand1x    (hand1x),
        .hand2x    (hand2x),
        .hand1y    (hand1y),
        .hand2y    (hand2y),
        .grab1     (grab1),
        .grab2     (grab2),
        .track1    (track1),
        .track2    (track2),
        .update    (update),
        .frame_drop(frame_drop)
    );

    typedef struct {
        logic [10:0] h1x, h2x;
        logic [9:0]  h1y, h2y;
        logic        t1, t2, g1, g2;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t nxt;
    int   cyc = 0;
    int   n_cmp = 0, n_fail = 0, n_upd = 0, n_drop = 0;
    logic [45:0] cur_o, prev_o;
    bit          stable;

    assign cur_o = {hand1x, hand1y, hand2x, hand2y, grab1, grab2, track1, track2};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every update strobe.
    initial begin
        exp_t e;
        stable = 1'b1;
        prev_o = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_o = cur_o;
                stable = 1'b1;
            end else begin
                if (frame_drop) n_drop++;
                if (update) begin
                    n_upd++;
                    n_cmp++;
                    if (!stable) begin
                        n_fail++;
                        $display("FAIL output_stability: outputs changed between updates, want held");
                    end
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_update: got update at cycle %0d, want none", cyc);
                    end else begin
                        e = q.pop_front();
                        if (hand1x !== e.h1x || hand1y !== e.h1y || hand2x !== e.h2x ||
                            hand2y !== e.h2y || track1 !== e.t1 || track2 !== e.t2 ||
                            grab1 !== e.g1 || grab2 !== e.g2) begin
                            n_fail++;
                            $display("FAIL outputs: got h1=(%0d,%0d) h2=(%0d,%0d) t=%b%b g=%b%b, want h1=(%0d,%0d) h2=(%0d,%0d) t=%b%b g=%b%b",
                                     hand1x, hand1y, hand2x, hand2y, track1, track2, grab1, grab2,
                                     e.h1x, e.h1y, e.h2x, e.h2y, e.t1, e.t2, e.g1, e.g2);
                        end
                        n_cmp++;
                        if (cyc != e.cyc) begin
                            n_fail++;
                            $display("FAIL update_latency: got cycle %0d, want %0d", cyc, e.cyc);
                        end
                    end
                    prev_o = cur_o;
                    stable = 1'b1;
                end else if (cur_o !== prev_o) begin
                    stable = 1'b0;
                end
            end
        end
    end

    task automatic drive(input int x, input int y, input bit h1, input bit h2, input bit g1,
                         input bit g2, input bit v, input bit fe, input bit push);
        exp_t e;
        @(negedge clk);
        pix_valid = v;
        pix_x     = 11'(x);
        pix_y     = 10'(y);
        pix_hand1 = h1;
        pix_hand2 = h2;
        pix_grab1 = g1;
        pix_grab2 = g2;
        frame_end = fe;
        if (fe && push) begin
            e     = nxt;
            e.cyc = cyc + 134;
            q.push_back(e);
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fend(input bit push);
        drive(0, 0, 0, 0, 0, 0, 0, 1, push);
        quiet(1);
    endtask

    // w x h pixel block for one hand; the first ngrab pixels also carry that hand's grab marker.
    task automatic block(input int x0, input int w, input int y0, input int h, input int hand,
                         input int ngrab, input bit fe_last, input bit push);
        int k;
        k = 0;
        for (int yy = y0; yy < y0 + h; yy++) begin
            for (int xx = x0; xx < x0 + w; xx++) begin
                bit g    = (k < ngrab);
                bit last = (k == w * h - 1);
                drive(xx, yy, hand == 1, hand == 2, g && hand == 1, g && hand == 2, 1,
                      fe_last && last, push && fe_last && last);
                k++;
            end
        end
    endtask

    task automatic set_exp(input int h1x, input int h1y, input int h2x, input int h2y,
                           input bit t1, input bit t2, input bit g1, input bit g2);
        nxt.h1x = 11'(h1x);
        nxt.h1y = 10'(h1y);
        nxt.h2x = 11'(h2x);
        nxt.h2y = 10'(h2y);
        nxt.t1  = t1;
        nxt.t2  = t2;
        nxt.g1  = g1;
        nxt.g2  = g2;
        nxt.cyc = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL update_timeout: got %0d pending updates, want 0", q.size());
            q.delete();
        end
        quiet(2);
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (hand1x !== 11'd256 || hand1y !== 10'd384 || hand2x !== 11'd768 ||
            hand2y !== 10'd384 || {grab1, grab2, track1, track2} !== 4'b0000 ||
            update !== 1'b0 || frame_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got h1=(%0d,%0d) h2=(%0d,%0d) g=%b%b t=%b%b upd=%b drop=%b, want h1=(256,384) h2=(768,384) all flags 0",
                     name, hand1x, hand1y, hand2x, hand2y, grab1, grab2, track1, track2,
                     update, frame_drop);
        end
    endtask

    initial begin
        int k0;
        int upd0;
        quiet(4);
        @(negedge clk);
        reset = 1'b0;
        quiet(2);
        check_reset_outputs("reset_state");

        // Empty frame: nothing tracked, reset positions held.
        set_exp(256, 384, 768, 384, 0, 0, 0, 0);
        fend(1);
        wait_idle();

        // Both hands tracked; hand1 has a first grab candidate frame.
        set_exp(104, 204, 509, 602, 1, 1, 0, 0);
        block(100, 10, 200, 10, 1, 40, 0, 0);
        block(500, 20, 600, 5, 2, 0, 0, 0);
        fend(1);
        wait_idle();

        // Grab debounce: on after 2 frames, off after 2 frames, on again.
        set_exp(104, 204, 509, 602, 1, 0, 1, 0);
        block(100, 10, 200, 10, 1, 40, 0, 0);
        fend(1);
        wait_idle();
        set_exp(104, 204, 509, 602, 1, 0, 1, 0);
        block(100, 10, 200, 10, 1, 10, 0, 0);
        fend(1);
        wait_idle();
        set_exp(104, 204, 509, 602, 1, 0, 0, 0);
        block(100, 10, 200, 10, 1, 10, 0, 0);
        fend(1);
        wait_idle();
        set_exp(104, 204, 509, 602, 1, 0, 0, 0);
        block(100, 10, 200, 10, 1, 40, 0, 0);
        fend(1);
        wait_idle();
        set_exp(104, 204, 509, 602, 1, 0, 1, 0);
        block(100, 10, 200, 10, 1, 40, 0, 0);
        fend(1);
        wait_idle();

        // Too few glove pixels: track and grab drop, position held.
        set_exp(104, 204, 509, 602, 0, 0, 0, 0);
        block(0, 30, 0, 1, 1, 30, 0, 0);
        fend(1);
        wait_idle();

        // Second frame_end 50 cycles into the computation is dropped.
        set_exp(14, 24, 509, 602, 1, 0, 0, 0);
        block(10, 10, 20, 10, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        k0 = cyc;
        block(300, 10, 30, 4, 1, 0, 0, 0);
        while (cyc < k0 + 49) quiet(1);
        fend(0);
        wait_idle();
        n_cmp++;
        if (n_drop != 1) begin
            n_fail++;
            $display("FAIL frame_drop_count: got %0d, want 1", n_drop);
        end

        // 63 pixels plus one coincident with frame_end: exactly MIN_PIXELS.
        set_exp(3, 3, 509, 602, 1, 0, 0, 0);
        block(0, 8, 0, 8, 1, 0, 1, 1);
        quiet(1);
        wait_idle();

        // Reset 60 cycles into the computation: no update, reset values.
        upd0 = n_upd;
        block(600, 10, 100, 10, 1, 40, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        k0 = cyc;
        while (cyc < k0 + 59) quiet(1);
        @(negedge clk);
        reset = 1'b1;
        quiet(2);
        @(negedge clk);
        reset = 1'b0;
        quiet(200);
        n_cmp++;
        if (n_upd != upd0) begin
            n_fail++;
            $display("FAIL reset_abort_update: got %0d updates, want %0d", n_upd, upd0);
        end
        check_reset_outputs("reset_abort_outputs");

        // Pipeline is idle again after the aborted computation.
        set_exp(256, 384, 768, 384, 0, 0, 0, 0);
        fend(1);
        wait_idle();
        n_cmp++;
        if (n_drop != 1) begin
            n_fail++;
            $display("FAIL frame_drop_total: got %0d, want 1", n_drop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
